// File: rtl/sda_kernel_ap_ctrl.sv
// sda_kernel_ap_ctrl: SDAccel ap_ctrl register bank (CTRL/GIE/IER/ISR) driving
// the four-phase go/done handshake of the action core and the kernel interrupt.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | ap_idle=1, waiting for ap_start
// GO_REQ   | go_0r=1, waiting for go_0a=1
// GO_RTZ   | go_0r=0, waiting for go_0a=0
// RUN      | action running, waiting for done_0r=1
// DONE_ACK | done_0a=1, waiting for done_0r=0
module sda_kernel_ap_ctrl #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  reg_req,
  output logic                  reg_ack,
  input  logic                  reg_write_en,
  input  logic [ADDR_WIDTH-1:0] reg_addr,
  input  logic [31:0]           reg_wdata,
  output logic [31:0]           reg_rdata,
  output logic                  go_0r,
  input  logic                  go_0a,
  input  logic                  done_0r,
  output logic                  done_0a,
  output logic                  interrupt
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GO_REQ,
    ST_GO_RTZ,
    ST_RUN,
    ST_DONE_ACK
  } state_t;

  state_t      state_q, state_d;
  logic        go_0r_q, done_0a_q, idle_q;
  logic        ap_start_q, ap_start_d;
  logic        ap_done_q, ap_done_d;
  logic        ap_ready_q, ap_ready_d;
  logic        auto_q, auto_d;
  logic        gie_q, gie_d;
  logic [1:0]  ier_q, ier_d;
  logic [1:0]  isr_q, isr_d;
  logic        reg_ack_q;
  logic [31:0] rdata_q, rdata_d;
  logic        irq_q;

  logic        start_clr, done_evt, restart_evt;
  logic        acc, wr, rd;
  logic        sel_ctrl, sel_gie, sel_ier, sel_isr;
  logic [31:0] rd_mux;
  logic        unused_wdata;

  // Host bits that no register implements.
  assign unused_wdata = ^{reg_wdata[31:8], reg_wdata[6:2]};

  assign acc      = reg_req & ~reg_ack_q;
  assign wr       = acc & reg_write_en;
  assign rd       = acc & ~reg_write_en;
  assign sel_ctrl = (reg_addr == ADDR_WIDTH'(0));
  assign sel_gie  = (reg_addr == ADDR_WIDTH'(1));
  assign sel_ier  = (reg_addr == ADDR_WIDTH'(2));
  assign sel_isr  = (reg_addr == ADDR_WIDTH'(3));

  // Action FSM next-state and handshake events.
  always_comb begin
    state_d     = state_q;
    start_clr   = 1'b0;
    done_evt    = 1'b0;
    restart_evt = 1'b0;
    unique case (state_q)
      ST_IDLE:     if (ap_start_q) state_d = ST_GO_REQ;
      ST_GO_REQ:   if (go_0a) begin
                     start_clr = 1'b1;
                     state_d   = ST_GO_RTZ;
                   end
      ST_GO_RTZ:   if (!go_0a) state_d = ST_RUN;
      ST_RUN:      if (done_0r) begin
                     done_evt = 1'b1;
                     state_d  = ST_DONE_ACK;
                   end
      ST_DONE_ACK: if (!done_0r) begin
                     restart_evt = auto_q;
                     state_d     = ST_IDLE;
                   end
      default:     state_d = ST_IDLE;
    endcase
  end

  // Read mux; ap_idle comes from the registered idle flag.
  always_comb begin
    rd_mux = 32'h0;
    if (sel_ctrl) rd_mux = {24'h0, auto_q, 3'b000, ap_ready_q, idle_q, ap_done_q, ap_start_q};
    else if (sel_gie) rd_mux = {31'h0, gie_q};
    else if (sel_ier) rd_mux = {30'h0, ier_q};
    else if (sel_isr) rd_mux = {30'h0, isr_q};
  end

  // Register next values; hardware sets win over clear-on-read and ISR toggles.
  always_comb begin
    ap_start_d = (ap_start_q & ~start_clr) | (wr & sel_ctrl & reg_wdata[0]) | restart_evt;
    ap_done_d  = done_evt | (ap_done_q  & ~(rd & sel_ctrl));
    ap_ready_d = done_evt | (ap_ready_q & ~(rd & sel_ctrl));
    auto_d     = (wr & sel_ctrl) ? reg_wdata[7] : auto_q;
    gie_d      = (wr & sel_gie)  ? reg_wdata[0] : gie_q;
    ier_d      = (wr & sel_ier)  ? reg_wdata[1:0] : ier_q;
    isr_d      = (isr_q ^ ((wr & sel_isr) ? reg_wdata[1:0] : 2'b00)) | {done_evt, done_evt};
    rdata_d    = rd ? rd_mux : rdata_q;
  end

  // State, FSM outputs and register bank.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= ST_IDLE;
      go_0r_q    <= 1'b0;
      done_0a_q  <= 1'b0;
      idle_q     <= 1'b1;
      ap_start_q <= 1'b0;
      ap_done_q  <= 1'b0;
      ap_ready_q <= 1'b0;
      auto_q     <= 1'b0;
      gie_q      <= 1'b0;
      ier_q      <= 2'b00;
      isr_q      <= 2'b00;
      reg_ack_q  <= 1'b0;
      rdata_q    <= 32'h0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      go_0r_q    <= (state_d == ST_GO_REQ);
      done_0a_q  <= (state_d == ST_DONE_ACK);
      idle_q     <= (state_d == ST_IDLE);
      ap_start_q <= ap_start_d;
      ap_done_q  <= ap_done_d;
      ap_ready_q <= ap_ready_d;
      auto_q     <= auto_d;
      gie_q      <= gie_d;
      ier_q      <= ier_d;
      isr_q      <= isr_d;
      // ack follows req one cycle late: rises after the accept, drops after req falls
      reg_ack_q  <= reg_req;
      rdata_q    <= rdata_d;
      irq_q      <= gie_q & |(isr_q & ier_q);
    end
  end

  assign go_0r     = go_0r_q;
  assign done_0a   = done_0a_q;
  assign reg_ack   = reg_ack_q;
  assign reg_rdata = rdata_q;
  assign interrupt = irq_q;

endmodule

// File: tb/tb_sda_kernel_ap_ctrl.sv
// Bench for sda_kernel_ap_ctrl: register table, handshake runs, same-cycle
// priority corners and asynchronous reset mid-handshake.
module tb_sda_kernel_ap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reg_req = 1'b0;
  logic        reg_we = 1'b0;
  logic [3:0]  reg_addr = 4'h0;
  logic [31:0] reg_wdata = 32'h0;
  logic        go_0a = 1'b0;
  logic        done_0r = 1'b0;
  logic        reg_ack, go_0r, done_0a, interrupt;
  logic [31:0] reg_rdata;

  int checks = 0;
  int failures = 0;

  sda_kernel_ap_ctrl #(.ADDR_WIDTH(4)) dut (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .reg_req(reg_req), .reg_ack(reg_ack), .reg_write_en(reg_we),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .go_0r(go_0r), .go_0a(go_0a), .done_0r(done_0r), .done_0a(done_0a),
    .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] exp;
    string       name;
  } sb_t;
  sb_t sb_q[$];
  bit  cur_rd;

  typedef struct {
    bit          wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[25];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return go_0r;
      1:       return done_0a;
      default: return reg_ack;
    endcase
  endfunction

  task automatic wait_for(input string name, input int which, input logic want);
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (sig(which) === want) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s timeout actual=%b required=%b", name, sig(which), want);
    end
  endtask

  task automatic start_access(input bit wr, input logic [3:0] a, input logic [31:0] d,
                              input logic [31:0] exp, input string name);
    reg_req   = 1'b1;
    reg_we    = wr;
    reg_addr  = a;
    reg_wdata = d;
    cur_rd    = !wr;
    if (!wr) sb_q.push_back('{exp, name});
  endtask

  task automatic complete_access();
    sb_t e;
    wait_for("ack_rise", 2, 1'b1);
    if (cur_rd && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.name, reg_rdata, e.exp);
    end
    reg_req = 1'b0;
    reg_we  = 1'b0;
    wait_for("ack_fall", 2, 1'b0);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d);
    start_access(1'b1, a, d, 32'h0, "");
    complete_access();
  endtask

  task automatic do_read(input logic [3:0] a, input logic [31:0] exp, input string name);
    start_access(1'b0, a, 32'h0, exp, name);
    complete_access();
  endtask

  // Action-core side of the go handshake; returns one cycle into RUN.
  task automatic go_phase();
    wait_for("go_rise", 0, 1'b1);
    go_0a = 1'b1;
    wait_for("go_fall", 0, 1'b0);
    go_0a = 1'b0;
    @(negedge clk);
  endtask

  task automatic done_phase(input bit chk_irq, input int dly);
    repeat (dly) @(negedge clk);
    done_0r = 1'b1;
    if (chk_irq) begin
      @(negedge clk);
      chk("done_ack_latency", {31'h0, done_0a}, 32'h1);
      chk("irq_not_yet", {31'h0, interrupt}, 32'h0);
      @(negedge clk);
      chk("irq_rise", {31'h0, interrupt}, 32'h1);
    end else begin
      wait_for("done_ack_rise", 1, 1'b1);
    end
    done_0r = 1'b0;
    wait_for("done_ack_fall", 1, 1'b0);
  endtask

  task automatic hit_reset();
    #2 rst_n = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    go_0a   = 1'b0;
    done_0r = 1'b0;
    reg_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    tbl[0]  = '{1'b0, 4'd0, 32'h0,        32'h4};
    tbl[1]  = '{1'b0, 4'd1, 32'h0,        32'h0};
    tbl[2]  = '{1'b0, 4'd2, 32'h0,        32'h0};
    tbl[3]  = '{1'b0, 4'd3, 32'h0,        32'h0};
    tbl[4]  = '{1'b0, 4'd9, 32'h0,        32'h0};
    tbl[5]  = '{1'b1, 4'd1, 32'hFFFFFFFF, 32'h0};
    tbl[6]  = '{1'b0, 4'd1, 32'h0,        32'h1};
    tbl[7]  = '{1'b1, 4'd2, 32'hFFFFFFFF, 32'h0};
    tbl[8]  = '{1'b0, 4'd2, 32'h0,        32'h3};
    tbl[9]  = '{1'b1, 4'd7, 32'hFFFFFFFF, 32'h0};
    tbl[10] = '{1'b0, 4'd7, 32'h0,        32'h0};
    tbl[11] = '{1'b1, 4'd0, 32'h0000008E, 32'h0};
    tbl[12] = '{1'b0, 4'd0, 32'h0,        32'h84};
    tbl[13] = '{1'b1, 4'd3, 32'h3,        32'h0};
    tbl[14] = '{1'b0, 4'd3, 32'h0,        32'h3};
    tbl[15] = '{1'b1, 4'd3, 32'h1,        32'h0};
    tbl[16] = '{1'b0, 4'd3, 32'h0,        32'h2};
    tbl[17] = '{1'b1, 4'd3, 32'h2,        32'h0};
    tbl[18] = '{1'b0, 4'd3, 32'h0,        32'h0};
    tbl[19] = '{1'b1, 4'd0, 32'h0,        32'h0};
    tbl[20] = '{1'b0, 4'd0, 32'h0,        32'h4};
    tbl[21] = '{1'b1, 4'd1, 32'h0,        32'h0};
    tbl[22] = '{1'b1, 4'd2, 32'h0,        32'h0};
    tbl[23] = '{1'b0, 4'd1, 32'h0,        32'h0};
    tbl[24] = '{1'b0, 4'd2, 32'h0,        32'h0};

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_ack",   {31'h0, reg_ack},   32'h0);
    chk("rst_go",    {31'h0, go_0r},     32'h0);
    chk("rst_done",  {31'h0, done_0a},   32'h0);
    chk("rst_irq",   {31'h0, interrupt}, 32'h0);
    chk("rst_rdata", reg_rdata,          32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // register table
    for (int i = 0; i < 25; i++) begin
      if (tbl[i].wr) do_write(tbl[i].addr, tbl[i].data);
      else do_read(tbl[i].addr, tbl[i].exp, $sformatf("tbl%0d", i));
    end

    // single run, clear-on-read
    do_write(4'd0, 32'h1);
    chk("start_latency", {31'h0, go_0r}, 32'h1);
    go_phase();
    done_phase(1'b0, 5);
    do_read(4'd0, 32'hE, "ctrl_after_run");
    do_read(4'd0, 32'h4, "ctrl_cor");

    // interrupt path
    do_write(4'd3, 32'h3);
    do_write(4'd1, 32'h1);
    do_write(4'd2, 32'h1);
    chk("irq_quiet", {31'h0, interrupt}, 32'h0);
    do_write(4'd0, 32'h1);
    go_phase();
    done_phase(1'b1, 5);
    do_write(4'd3, 32'h1);
    chk("irq_fall", {31'h0, interrupt}, 32'h0);
    do_read(4'd3, 32'h2, "isr_ready_left");
    do_write(4'd1, 32'h0);
    do_read(4'd0, 32'hE, "ctrl_irq_run");

    // auto-restart: three runs from one write, then stop
    do_write(4'd0, 32'h81);
    for (int r = 0; r < 3; r++) begin
      go_phase();
      if (r < 2) begin
        done_phase(1'b0, 3);
        chk($sformatf("auto_go_low%0d", r), {31'h0, go_0r}, 32'h0);
        @(negedge clk);
        chk($sformatf("auto_go_rise%0d", r), {31'h0, go_0r}, 32'h1);
      end else begin
        do_write(4'd0, 32'h0);
        done_phase(1'b0, 3);
      end
    end
    repeat (5) @(negedge clk);
    chk("auto_stopped", {31'h0, go_0r}, 32'h0);
    do_read(4'd0, 32'hE, "ctrl_auto_end");
    do_read(4'd0, 32'h4, "ctrl_auto_idle");

    // clear-on-read in the same cycle as the done event
    do_write(4'd0, 32'h1);
    go_phase();
    start_access(1'b0, 4'd0, 32'h0, 32'h0, "cor_same_cycle");
    done_0r = 1'b1;
    complete_access();
    do_read(4'd0, 32'hA, "cor_after_set");
    done_phase(1'b0, 0);

    // ISR toggle in the same cycle as the done event
    do_write(4'd0, 32'h1);
    go_phase();
    start_access(1'b1, 4'd3, 32'h1, 32'h0, "");
    done_0r = 1'b1;
    complete_access();
    done_phase(1'b0, 0);
    do_read(4'd3, 32'h3, "isr_set_wins");

    // asynchronous reset in GO_REQ
    do_write(4'd0, 32'h1);
    chk("goreq_go_high", {31'h0, go_0r}, 32'h1);
    hit_reset();
    chk("rst_goreq_go", {31'h0, go_0r}, 32'h0);
    release_reset();
    do_read(4'd0, 32'h4, "ctrl_after_rst_goreq");

    // asynchronous reset in RUN
    do_write(4'd0, 32'h1);
    go_phase();
    hit_reset();
    chk("rst_run_go",   {31'h0, go_0r},   32'h0);
    chk("rst_run_done", {31'h0, done_0a}, 32'h0);
    release_reset();
    do_read(4'd0, 32'h4, "ctrl_after_rst_run");

    // asynchronous reset in DONE_ACK
    do_write(4'd0, 32'h1);
    go_phase();
    done_0r = 1'b1;
    wait_for("done_ack_pre_rst", 1, 1'b1);
    hit_reset();
    chk("rst_doneack_done", {31'h0, done_0a}, 32'h0);
    release_reset();
    do_read(4'd0, 32'h4, "ctrl_after_rst_done");
    do_read(4'd3, 32'h0, "isr_after_rst");

    // normal start after reset
    do_write(4'd0, 32'h1);
    chk("restart_latency", {31'h0, go_0r}, 32'h1);
    go_phase();
    done_phase(1'b0, 2);
    do_read(4'd0, 32'hE, "ctrl_post_reset_run");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
